// File: rtl/ascii_pkg.sv
// ASCII constants and FSM/snapshot types shared by the terminal-facing
// encoder and key decoder.
package ascii_pkg;

    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_AT    = 8'h40;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_QMARK = 8'h3F;

    // Character slots 0..7 are HH:MM:SS; the optional tail uses fixed slots.
    localparam logic [3:0] IDX_S0 = 4'd7;
    localparam logic [3:0] IDX_AT = 4'd8;
    localparam logic [3:0] IDX_CR = 4'd9;
    localparam logic [3:0] IDX_LF = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } tx_state_t;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        logic       alarm;
    } time_snap_t;

endpackage

// File: rtl/bcd_to_ascii.sv
// One BCD digit to its ASCII character; non-decimal codes become "?".
module bcd_to_ascii
    import ascii_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = (bcd <= 4'd9) ? (ASC_ZERO | {4'h0, bcd}) : ASC_QMARK;
    end

endmodule

// File: rtl/encode_time_msg.sv
// Streams a snapshot of the clock time as "HH:MM:SS[@][\r\n]" to a UART TX
// byte interface, one character per valid/ready handshake.
module encode_time_msg
    import ascii_pkg::*;
#(
    parameter bit         CR_LF    = 1'b1,
    parameter logic [7:0] SEP_CHAR = 8'h3A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] hr_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       alarm_flag,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    tx_state_t  state_q, state_d;
    logic [3:0] index_q, index_d;
    time_snap_t snap_q, snap_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] last_idx;
    logic [3:0] next_idx;
    logic [3:0] digit_sel;
    logic [7:0] digit_ascii;
    logic [7:0] char_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            snap_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            snap_q     <= snap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Absent optional characters are skipped so the stream has no bubbles.
    always_comb begin
        last_idx = CR_LF ? IDX_LF : (snap_q.alarm ? IDX_AT : IDX_S0);
        if (index_q == IDX_S0) begin
            next_idx = snap_q.alarm ? IDX_AT : IDX_CR;
        end else begin
            next_idx = index_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        snap_d  = snap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d  = '{h1: hr_tens, h0: hr_ones, m1: min_tens,
                                m0: min_ones, s1: sec_tens, s0: sec_ones,
                                alarm: alarm_flag};
                    index_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (index_q == last_idx) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = next_idx;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers are loaded from next-state values, so the first
    // character appears the cycle after start and stalls hold the byte.
    always_comb begin
        unique case (index_d)
            4'd0:    digit_sel = snap_d.h1;
            4'd1:    digit_sel = snap_d.h0;
            4'd3:    digit_sel = snap_d.m1;
            4'd4:    digit_sel = snap_d.m0;
            4'd6:    digit_sel = snap_d.s1;
            4'd7:    digit_sel = snap_d.s0;
            default: digit_sel = '0;
        endcase
    end

    bcd_to_ascii u_bcd_to_ascii (
        .bcd   (digit_sel),
        .ascii (digit_ascii)
    );

    always_comb begin
        unique case (index_d)
            4'd2, 4'd5: char_d = SEP_CHAR;
            IDX_AT:     char_d = ASC_AT;
            IDX_CR:     char_d = ASC_CR;
            IDX_LF:     char_d = ASC_LF;
            default:    char_d = digit_ascii;
        endcase
        tx_valid_d = (state_d == ST_SEND);
        tx_data_d  = tx_valid_d ? char_d : tx_data_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_encode_time_msg.sv
// Self-checking bench: a CR_LF=1 and a CR_LF=0 instance share stimulus; a
// scoreboard queue per instance holds the expected byte stream.
module tb_encode_time_msg;

    logic       clk = 1'b0;
    logic       rst, start, alarm_flag, tx_ready;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b, busy_a, busy_b, done_a, done_b;

    encode_time_msg #(.CR_LF(1'b1), .SEP_CHAR(8'h3A)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .alarm_flag(alarm_flag), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready), .busy(busy_a), .done(done_a)
    );

    encode_time_msg #(.CR_LF(1'b0), .SEP_CHAR(8'h3A)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .alarm_flag(alarm_flag), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         stall_a = 0, stall_b = 0;
    logic [7:0] cap[16];
    int         cap_n = 0;
    bit         ready_toggle = 1'b0;
    int         phase = 0;

    // tx_ready pattern 1,0,0,1 when toggling, otherwise held high.
    always @(posedge clk) begin
        #1;
        if (ready_toggle) begin
            tx_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            phase++;
        end else begin
            tx_ready = 1'b1;
        end
    end

    logic       stall_pa = 1'b0, stall_pb = 1'b0;
    logic [7:0] hold_a = '0, hold_b = '0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (stall_pa) check("hold_a", 32'({tx_valid_a, tx_data_a}), 32'({1'b1, hold_a}));
        if (stall_pb) check("hold_b", 32'({tx_valid_b, tx_data_b}), 32'({1'b1, hold_b}));
        stall_pa = tx_valid_a && !tx_ready;
        stall_pb = tx_valid_b && !tx_ready;
        hold_a   = tx_data_a;
        hold_b   = tx_data_b;
        if (stall_pa) stall_a++;
        if (stall_pb) stall_b++;
        if (tx_valid_a && tx_ready) begin
            if (qa.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL extra_byte_a: got %0h, expected none", tx_data_a);
            end else begin
                e = qa.pop_front();
                check("byte_a", 32'(tx_data_a), 32'(e));
                if (cap_n < 16) begin cap[cap_n] = tx_data_a; cap_n++; end
            end
        end
        if (tx_valid_b && tx_ready) begin
            if (qb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL extra_byte_b: got %0h, expected none", tx_data_b);
            end else begin
                e = qb.pop_front();
                check("byte_b", 32'(tx_data_b), 32'(e));
            end
        end
    end

    function automatic logic [7:0] asc(input logic [3:0] v);
        return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
    endfunction

    task automatic push_msg(input logic [23:0] d, input logic al);
        logic [7:0] m[$];
        m = '{asc(d[23:20]), asc(d[19:16]), 8'h3A, asc(d[15:12]), asc(d[11:8]),
              8'h3A, asc(d[7:4]), asc(d[3:0])};
        if (al) m.push_back(8'h40);
        foreach (m[i]) begin qa.push_back(m[i]); qb.push_back(m[i]); end
        qa.push_back(8'h0D);
        qa.push_back(8'h0A);
    endtask

    task automatic drive_digits(input logic [23:0] d);
        {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = d;
    endtask

    // mode 0: plain, 1: digits changed and start re-pulsed mid-message,
    // 2: rst asserted while the 4th byte is on the interface.
    task automatic run_msg(input logic [23:0] d, input logic al, input bit tog,
                           input int len_a, input int len_b, input logic [7:0] b8,
                           input int mode);
        int dc_a, dc_b;
        @(posedge clk); #2;
        drive_digits(d);
        alarm_flag = al;
        push_msg(d, al);
        stall_a = 0; stall_b = 0; cap_n = 0; phase = 0;
        ready_toggle = tog;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        drive_digits($urandom);
        alarm_flag = ~al;
        dc_a = 0; dc_b = 0;
        for (int c = 1; c <= 200 && dc_a == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("first_valid_a", 32'(tx_valid_a), 32'd1);
                check("first_busy_a", 32'(busy_a), 32'd1);
            end
            if (done_b && dc_b == 0) dc_b = c;
            if (done_a) dc_a = c;
            else if (mode == 1) check("busy_held_a", 32'(busy_a), 32'd1);
            if (mode == 1 && c == 3) begin start = 1'b1; drive_digits(24'h987654); end
            if (mode == 1 && c == 4) start = 1'b0;
            if (mode == 2 && c == 4) begin rst = 1'b1; break; end
        end
        if (mode == 2) begin
            @(negedge clk);
            check("rst_valid_a", 32'(tx_valid_a), 32'd0);
            check("rst_busy_a", 32'(busy_a), 32'd0);
            check("rst_done_a", 32'(done_a), 32'd0);
            check("rst_valid_b", 32'(tx_valid_b), 32'd0);
            rst = 1'b0;
            qa.delete();
            qb.delete();
            ready_toggle = 1'b0;
            return;
        end
        check("done_cycle_a", 32'(dc_a), 32'(len_a + 1 + stall_a));
        check("done_cycle_b", 32'(dc_b), 32'(len_b + 1 + stall_b));
        check("len_a", 32'(cap_n), 32'(len_a));
        check("byte8_a", 32'(cap[7]), 32'(b8));
        @(negedge clk);
        check("done_pulse_a", 32'(done_a), 32'd0);
        check("idle_busy_a", 32'(busy_a), 32'd0);
        check("queue_a_empty", 32'(qa.size()), 32'd0);
        check("queue_b_empty", 32'(qb.size()), 32'd0);
        ready_toggle = 1'b0;
        repeat (3) @(negedge clk);
        check("stay_idle_a", 32'(tx_valid_a), 32'd0);
    endtask

    typedef struct {
        logic [23:0] digits;
        logic        alarm;
        bit          toggle;
        int          len_a;
        int          len_b;
        logic [7:0]  byte8;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] exp0[10];

    initial begin
        vecs[0] = '{24'h120559, 1'b0, 1'b0, 10, 8, 8'h39};
        vecs[1] = '{24'h120559, 1'b1, 1'b0, 11, 9, 8'h39};
        vecs[2] = '{24'h120559, 1'b1, 1'b1, 11, 9, 8'h39};
        vecs[3] = '{24'h23595C, 1'b0, 1'b0, 10, 8, 8'h3F};
        vecs[4] = '{24'h000000, 1'b1, 1'b1, 11, 9, 8'h30};
        vecs[5] = '{24'hFA9B00, 1'b0, 1'b0, 10, 8, 8'h30};
        exp0 = '{8'h31, 8'h32, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};

        rst = 1'b1; start = 1'b0; alarm_flag = 1'b0; tx_ready = 1'b1;
        drive_digits(24'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data_a", 32'(tx_data_a), 32'h00);
        check("reset_valid_a", 32'(tx_valid_a), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_done_a", 32'(done_a), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_msg(vecs[i].digits, vecs[i].alarm, vecs[i].toggle,
                    vecs[i].len_a, vecs[i].len_b, vecs[i].byte8, 0);
            if (i == 0) begin
                for (int j = 0; j < 10; j++) check("literal_msg0", 32'(cap[j]), 32'(exp0[j]));
            end
        end

        run_msg(24'h120559, 1'b1, 1'b0, 11, 9, 8'h39, 1);
        run_msg(24'h120559, 1'b0, 1'b0, 10, 8, 8'h39, 2);
        run_msg(24'h083017, 1'b1, 1'b0, 11, 9, 8'h37, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
